dut_top_unit: RTL and testbench

- Registered 4-operation arithmetic/logic unit: the core DUT wrapped by the block-level top.
- Accepts one operand pair per valid-qualified cycle and returns the result one clock later with a matching valid strobe.
- Counts accepted transactions for scoreboard cross-checking.
- Sits behind the block-level interface bundle (clock, reset, operand and result signals) driven by the bench.

---
 rtl/dut_top_unit.sv | 67 ++++++
 tb/tb_dut_top_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dut_top_unit.sv
// Registered 4-operation ALU (add, sub, AND, XOR) with a one-cycle
// result latency, a matching valid strobe and a saturating count of
// accepted transactions. All outputs come straight from flops.
module dut_top_unit #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic                 valid,
  output logic [WIDTH:0]       c,
  output logic                 valid_out,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] result;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  // Next result; the (WIDTH+1)-bit subtraction leaves the borrow in the top bit
  always_comb begin
    result = '0;
    case (op_t'(op))
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_AND:  result = {1'b0, a & b};
      OP_XOR:  result = {1'b0, a ^ b};
      default: result = '0;
    endcase
  end

  // Capture result and strobe on accepted cycles; c holds when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c         <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid;
      if (valid) begin
        c <= result;
      end
    end
  end

  // Saturating count of accepted transactions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (valid && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dut_top_unit.sv
// Self-checking bench for dut_top_unit: expected results are queued when
// stimulus is driven and compared when valid_out is observed.
module tb_dut_top_unit;

  localparam int W  = 4;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          valid;
  logic [W:0]    c;
  logic          valid_out;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  logic [W:0] sb[$];
  logic [W:0] last_c;
  int         exp_cnt;
  bit         mon_en = 1'b0;

  dut_top_unit #(.WIDTH(W), .CNT_WIDTH(CW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .op        (op),
    .valid     (valid),
    .c         (c),
    .valid_out (valid_out),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input int x, input int y, input int o);
    int r;
    case (o)
      0:       r = x + y;
      1:       r = (x >= y) ? (x - y) : ((x - y + (1 << W)) + (1 << W));
      2:       r = x & y;
      default: r = x ^ y;
    endcase
    return r[W:0];
  endfunction

  task automatic send(input int x, input int y, input int o);
    @(negedge clk);
    #1;
    a     = x[W-1:0];
    b     = y[W-1:0];
    op    = o[1:0];
    valid = 1'b1;
    sb.push_back(model(x, y, o));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      valid = 1'b0;
      a     = 'x;
      b     = 'x;
      op    = 'x;
    end
  endtask

  // Scoreboard monitor: one pending result at most, due one cycle after drive
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        logic [W:0] e;
        e = sb.pop_front();
        check("valid_out_hi", 32'(valid_out), 32'd1);
        check("c_result", 32'(c), 32'(e));
        last_c = e;
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
      end else begin
        check("valid_out_lo", 32'(valid_out), 32'd0);
        check("c_hold", 32'(c), 32'(last_c));
      end
      check("count", 32'(count), 32'(exp_cnt));
    end
  end

  initial begin
    int base;
    reset = 1'b0;
    valid = 1'b0;
    a = '0; b = '0; op = '0;
    last_c  = '0;
    exp_cnt = 0;

    // Reset: valid pulsed while reset is asserted must be ignored
    #2;
    valid = 1'b1; a = 4'd3; b = 4'd4; op = 2'b00;
    #1;
    check("rst_c", 32'(c), 32'd0);
    check("rst_vo", 32'(valid_out), 32'd0);
    check("rst_cnt", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_c", 32'(c), 32'd0);
    check("rst_edge_vo", 32'(valid_out), 32'd0);
    check("rst_edge_cnt", 32'(count), 32'd0);
    #2;
    reset = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    check("rel_c", 32'(c), 32'd0);
    check("rel_vo", 32'(valid_out), 32'd0);
    check("rel_cnt", 32'(count), 32'd0);
    mon_en = 1'b1;

    // Add with carry, then hold
    send(9, 8, 0);
    idle(2);
    check("add_carry_c", 32'(c), 32'd17);

    // Sub with borrow, then back-to-back sub
    send(3, 5, 1);
    send(7, 2, 1);
    idle(1);

    // Logic ops
    send(12, 10, 2);
    send(12, 10, 3);
    idle(2);

    // Streaming: 20 random back-to-back transactions
    base = exp_cnt;
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, (1 << W) - 1)),
           int'($urandom_range(0, (1 << W) - 1)),
           int'($urandom_range(0, 3)));
    end
    idle(2);
    check("stream_count", 32'(count), 32'(base + 20));

    // Boundary operands
    send(15, 15, 0);
    send(0, 15, 1);
    send(15, 0, 1);
    send(0, 0, 1);
    send(15, 15, 3);
    idle(2);

    // Async reset one cycle after an accept
    @(negedge clk);
    mon_en = 1'b0;
    #1;
    a = 4'd15; b = 4'd15; op = 2'b00; valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_vo", 32'(valid_out), 32'd1);
    check("pre_rst_c", 32'(c), 32'd30);
    valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_c", 32'(c), 32'd0);
    check("async_vo", 32'(valid_out), 32'd0);
    check("async_cnt", 32'(count), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    last_c  = '0;
    exp_cnt = 0;
    mon_en  = 1'b1;
    idle(4);

    // Activity after reset recovery
    send(6, 5, 0);
    idle(2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
